// File: rtl/sort_stream_pipe.sv
// Pipelined bitonic sorter: one vector per cycle, stable ordering via {element, index} keys,
// per-vector direction, valid/ready with whole-pipe stall, synchronous flush.
module sort_stream_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_CNT   = 8,
    parameter int unsigned SIGNED     = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    flush,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic                                    in_dir,
    input  logic [DATA_WIDTH*DATA_CNT-1:0]          in_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    out_dir,
    output logic [DATA_WIDTH*DATA_CNT-1:0]          out_data,
    output logic [$clog2(DATA_CNT)*DATA_CNT-1:0]    out_idx
);

    localparam int unsigned K     = $clog2(DATA_CNT);
    localparam int unsigned IDX_W = K;
    localparam int unsigned LAT   = K * (K + 1) / 2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [IDX_W-1:0]      idx;
    } elem_t;

    // True when a must precede b in the final order of a vector sorted in direction desc.
    function automatic logic before_f(input elem_t a, input elem_t b, input logic desc);
        logic lt;
        logic gt;
        if (SIGNED != 0) begin
            lt = $signed(a.data) < $signed(b.data);
            gt = $signed(a.data) > $signed(b.data);
        end else begin
            lt = a.data < b.data;
            gt = a.data > b.data;
        end
        if (a.data == b.data) begin
            before_f = a.idx < b.idx;
        end else begin
            before_f = desc ? gt : lt;
        end
    endfunction

    logic [LAT-1:0]             vld_q;
    logic [LAT-1:0]             vld_d;
    logic [LAT-1:0]             dir_q;
    logic [LAT-1:0]             dir_d;
    elem_t [DATA_CNT-1:0]       el_q [LAT];
    elem_t [DATA_CNT-1:0]       el_d [LAT];
    elem_t [DATA_CNT-1:0]       in_el;
    logic                       adv_c;
    logic                       xfer_c;

    assign adv_c    = !vld_q[LAT-1] || out_ready;
    assign in_ready = adv_c && !flush;
    assign xfer_c   = in_valid && in_ready;

    // Unpack the input bus and tag each element with its original slot.
    always_comb begin
        in_el = '0;
        for (int unsigned i = 0; i < DATA_CNT; i++) begin
            in_el[i].data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            in_el[i].idx  = IDX_W'(i);
        end
    end

    // One compare-exchange layer per pipeline stage: merge phase P, step distance 2**Q.
    for (genvar P = 0; P < K; P++) begin : g_merge
        for (genvar Q = P; Q >= 0; Q--) begin : g_step
            localparam int unsigned S    = P * (P + 1) / 2 + (P - Q);
            localparam int unsigned DIST = 32'd1 << Q;
            localparam int unsigned BLK  = 32'd2 << P;

            elem_t [DATA_CNT-1:0] src_c;
            elem_t [DATA_CNT-1:0] net_c;
            logic                 src_dir_c;

            if (S == 0) begin : g_first
                assign src_c     = in_el;
                assign src_dir_c = in_dir;
            end else begin : g_chain
                assign src_c     = el_q[S-1];
                assign src_dir_c = dir_q[S-1];
            end

            always_comb begin
                net_c = src_c;
                for (int unsigned i = 0; i < DATA_CNT; i++) begin
                    if ((i & DIST) == 32'd0) begin
                        if ((i & BLK) == 32'd0) begin
                            if (before_f(src_c[IDX_W'(i + DIST)], src_c[IDX_W'(i)], src_dir_c)) begin
                                net_c[IDX_W'(i)]        = src_c[IDX_W'(i + DIST)];
                                net_c[IDX_W'(i + DIST)] = src_c[IDX_W'(i)];
                            end
                        end else if (before_f(src_c[IDX_W'(i)], src_c[IDX_W'(i + DIST)], src_dir_c)) begin
                            net_c[IDX_W'(i)]        = src_c[IDX_W'(i + DIST)];
                            net_c[IDX_W'(i + DIST)] = src_c[IDX_W'(i)];
                        end
                    end
                end
            end

            assign el_d[S] = net_c;
        end
    end

    // Valid and direction shift alongside the data; a bubble enters when nothing transfers.
    always_comb begin
        vld_d    = vld_q;
        dir_d    = dir_q;
        vld_d[0] = xfer_c;
        dir_d[0] = in_dir;
        for (int unsigned s = 1; s < LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            dir_d[s] = dir_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dir_q <= '0;
            for (int unsigned s = 0; s < LAT; s++) begin
                el_q[s] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else if (adv_c) begin
            vld_q <= vld_d;
            dir_q <= dir_d;
            for (int unsigned s = 0; s < LAT; s++) begin
                el_q[s] <= el_d[s];
            end
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_dir   = dir_q[LAT-1];

    always_comb begin
        out_data = '0;
        out_idx  = '0;
        for (int unsigned i = 0; i < DATA_CNT; i++) begin
            out_data[i*DATA_WIDTH +: DATA_WIDTH] = el_q[LAT-1][i].data;
            out_idx[i*IDX_W +: IDX_W]            = el_q[LAT-1][i].idx;
        end
    end

endmodule

// File: tb/tb_sort_stream_pipe.sv
// Bench for sort_stream_pipe: unsigned and signed instances share stimulus and are checked
// against a queue-based reference sort every cycle, plus hand-computed vectors.
module tb_sort_stream_pipe;

    localparam int unsigned W   = 8;
    localparam int unsigned N   = 8;
    localparam int unsigned IW  = 3;
    localparam int unsigned LAT = 6;
    localparam int unsigned DW  = W * N;
    localparam int unsigned XW  = IW * N;

    typedef struct {
        logic [DW-1:0] data;
        logic [XW-1:0] idx;
        logic          dir;
    } exp_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_dir    = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          out_ready = 1'b1;

    logic          u_in_ready, u_out_valid, u_out_dir;
    logic [DW-1:0] u_out_data;
    logic [XW-1:0] u_out_idx;
    logic          s_in_ready, s_out_valid, s_out_dir;
    logic [DW-1:0] s_out_data;
    logic [XW-1:0] s_out_idx;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_out  = 0;
    exp_t q_u[$];
    exp_t q_s[$];

    logic [DW-1:0] cap_du, cap_ds;
    logic [XW-1:0] cap_iu;
    logic          cap_dir;

    sort_stream_pipe #(.DATA_WIDTH(W), .DATA_CNT(N), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_dir(in_dir), .in_data(in_data), .out_valid(u_out_valid), .out_ready(out_ready),
        .out_dir(u_out_dir), .out_data(u_out_data), .out_idx(u_out_idx)
    );

    sort_stream_pipe #(.DATA_WIDTH(W), .DATA_CNT(N), .SIGNED(1)) s_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_dir(in_dir), .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_dir(s_out_dir), .out_data(s_out_data), .out_idx(s_out_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event (cycle %0d)", nm, cyc);
    endtask

    function automatic bit first_f(input int ka, input int kb, input int ia, input int ib, input logic dir);
        if (ka == kb) return ia < ib;
        return dir ? (ka > kb) : (ka < kb);
    endfunction

    // Reference: stable insertion sort of original positions by element value.
    function automatic exp_t model(input logic [DW-1:0] d, input logic dir, input bit sgn);
        int   key[N];
        int   ord[N];
        int   tmp;
        exp_t r;
        for (int i = 0; i < N; i++) begin
            ord[i] = i;
            if (sgn) key[i] = int'($signed(d[i*W +: W]));
            else     key[i] = int'(d[i*W +: W]);
        end
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0 && first_f(key[ord[j]], key[ord[j-1]], ord[j], ord[j-1], dir); j--) begin
                tmp = ord[j]; ord[j] = ord[j-1]; ord[j-1] = tmp;
            end
        end
        r.data = '0;
        r.idx  = '0;
        for (int s = 0; s < N; s++) begin
            r.data[s*W +: W]   = d[ord[s]*W +: W];
            r.idx[s*IW +: IW]  = IW'(ord[s]);
        end
        r.dir = dir;
        return r;
    endfunction

    function automatic logic [DW-1:0] pk(input int v[N]);
        logic [DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(v[i]);
        return r;
    endfunction

    function automatic logic [XW-1:0] pkx(input int v[N]);
        logic [XW-1:0] r;
        for (int i = 0; i < N; i++) r[i*IW +: IW] = IW'(v[i]);
        return r;
    endfunction

    // Per-cycle compare against the reference queues, handshake rule and stall stability.
    initial begin
        exp_t          e;
        bit            stall_u;
        bit            stall_s;
        logic [DW-1:0] h_du, h_ds;
        logic [XW-1:0] h_iu, h_is;
        logic          h_ru, h_rs;
        stall_u = 1'b0;
        stall_s = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_out_valid", 64'(u_out_valid), 64'd0);
                chk("rst_in_ready",  64'(u_in_ready),  64'd1);
                chk("rst_out_data",  64'(u_out_data),  64'd0);
                chk("rst_out_idx",   64'(u_out_idx),   64'd0);
                chk("rst_out_dir",   64'(u_out_dir),   64'd0);
                chk("rst_s_valid",   64'(s_out_valid), 64'd0);
                chk("rst_s_data",    64'(s_out_data),  64'd0);
                q_u.delete();
                q_s.delete();
                stall_u = 1'b0;
                stall_s = 1'b0;
            end else begin
                chk("in_ready_u", 64'(u_in_ready), 64'((!u_out_valid || out_ready) && !flush));
                chk("in_ready_s", 64'(s_in_ready), 64'((!s_out_valid || out_ready) && !flush));
                if (stall_u) begin
                    chk("hold_valid_u", 64'(u_out_valid), 64'd1);
                    chk("hold_data_u",  64'(u_out_data),  64'(h_du));
                    chk("hold_idx_u",   64'(u_out_idx),   64'(h_iu));
                    chk("hold_dir_u",   64'(u_out_dir),   64'(h_ru));
                end
                if (stall_s) begin
                    chk("hold_valid_s", 64'(s_out_valid), 64'd1);
                    chk("hold_data_s",  64'(s_out_data),  64'(h_ds));
                    chk("hold_idx_s",   64'(s_out_idx),   64'(h_is));
                    chk("hold_dir_s",   64'(s_out_dir),   64'(h_rs));
                end
                if (flush) begin
                    q_u.delete();
                    q_s.delete();
                end else begin
                    if (u_out_valid && out_ready) begin
                        n_out++;
                        if (q_u.size() == 0) begin
                            chk("unexpected_out_u", 64'(u_out_data), 64'd0);
                            errors += (u_out_data == '0) ? 1 : 0;
                        end else begin
                            e = q_u.pop_front();
                            chk("out_data_u", 64'(u_out_data), 64'(e.data));
                            chk("out_idx_u",  64'(u_out_idx),  64'(e.idx));
                            chk("out_dir_u",  64'(u_out_dir),  64'(e.dir));
                        end
                    end
                    if (s_out_valid && out_ready) begin
                        if (q_s.size() == 0) begin
                            chk("unexpected_out_s", 64'(s_out_data), 64'd0);
                            errors += (s_out_data == '0) ? 1 : 0;
                        end else begin
                            e = q_s.pop_front();
                            chk("out_data_s", 64'(s_out_data), 64'(e.data));
                            chk("out_idx_s",  64'(s_out_idx),  64'(e.idx));
                            chk("out_dir_s",  64'(s_out_dir),  64'(e.dir));
                        end
                    end
                end
                if (in_valid && u_in_ready) q_u.push_back(model(in_data, in_dir, 1'b0));
                if (in_valid && s_in_ready) q_s.push_back(model(in_data, in_dir, 1'b1));
                stall_u = u_out_valid && !out_ready && !flush;
                stall_s = s_out_valid && !out_ready && !flush;
                h_du = u_out_data; h_iu = u_out_idx; h_ru = u_out_dir;
                h_ds = s_out_data; h_is = s_out_idx; h_rs = s_out_dir;
            end
        end
    end

    task automatic send_vec(input logic [DW-1:0] d, input logic dir, input bit rnd, output int t_acc);
        t_acc    = -1;
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        for (int k = 0; k < 200 && t_acc < 0; k++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (u_in_ready) t_acc = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (t_acc < 0) fail("accept_timeout");
    endtask

    task automatic wait_out(output int t_out);
        t_out = -1;
        for (int k = 0; k < 200 && t_out < 0; k++) begin
            @(negedge clk);
            if (u_out_valid) begin
                t_out   = cyc;
                cap_du  = u_out_data;
                cap_iu  = u_out_idx;
                cap_dir = u_out_dir;
                cap_ds  = s_out_data;
            end
            @(posedge clk); #1;
        end
        if (t_out < 0) fail("output_timeout");
    endtask

    task automatic count_valid(input int n, output int seen);
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (u_out_valid) seen++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int            a[N];
        int            t0, t1, seen, acc, stl, n0;
        logic [DW-1:0] dv, frz;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Distinct values ascending, then descending.
        a = '{5, 3, 7, 1, 0, 6, 2, 4};
        send_vec(pk(a), 1'b0, 1'b0, t0);
        wait_out(t1);
        chk("lat_basic", 64'(t1 - t0), 64'(LAT));
        a = '{0, 1, 2, 3, 4, 5, 6, 7};  chk("asc_data", 64'(cap_du), 64'(pk(a)));
        a = '{4, 3, 6, 1, 7, 0, 5, 2};  chk("asc_idx",  64'(cap_iu), 64'(pkx(a)));
        chk("asc_dir", 64'(cap_dir), 64'd0);

        a = '{5, 3, 7, 1, 0, 6, 2, 4};
        send_vec(pk(a), 1'b1, 1'b0, t0);
        wait_out(t1);
        a = '{7, 6, 5, 4, 3, 2, 1, 0};  chk("desc_data", 64'(cap_du), 64'(pk(a)));
        a = '{2, 5, 0, 7, 1, 6, 3, 4};  chk("desc_idx",  64'(cap_iu), 64'(pkx(a)));

        // All-equal descending keeps original order.
        a = '{9, 9, 9, 9, 9, 9, 9, 9};
        send_vec(pk(a), 1'b1, 1'b0, t0);
        wait_out(t1);
        chk("eq_data", 64'(cap_du), 64'(pk(a)));
        a = '{0, 1, 2, 3, 4, 5, 6, 7};  chk("eq_idx", 64'(cap_iu), 64'(pkx(a)));
        chk("eq_dir", 64'(cap_dir), 64'd1);

        // Signed versus unsigned interpretation of the same vector.
        a = '{128, 127, 255, 0, 1, 254, 2, 129};
        send_vec(pk(a), 1'b0, 1'b0, t0);
        wait_out(t1);
        a = '{128, 129, 254, 255, 0, 1, 2, 127};  chk("signed_data", 64'(cap_ds), 64'(pk(a)));
        a = '{0, 1, 2, 127, 128, 129, 254, 255};  chk("unsigned_data", 64'(cap_du), 64'(pk(a)));

        // Random stream with random backpressure; small ranges on odd vectors force ties.
        n0 = n_out;
        for (int v = 0; v < 20; v++) begin
            for (int i = 0; i < N; i++)
                dv[i*W +: W] = W'((v % 2 == 1) ? $urandom_range(0, 3) : $urandom_range(0, 255));
            send_vec(dv, 1'($urandom_range(0, 1)), 1'b1, t0);
        end
        for (int k = 0; k < 400 && q_u.size() != 0; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("rand_count", 64'(n_out - n0), 64'd20);
        chk("rand_empty", 64'(q_u.size()), 64'd0);

        // Fill the pipe against a stalled consumer, then drain one per cycle.
        out_ready = 1'b0;
        acc = 0;
        stl = 0;
        for (int k = 0; k < 40 && stl < 3; k++) begin
            for (int i = 0; i < N; i++) dv[i*W +: W] = W'($urandom_range(0, 255));
            in_valid = 1'b1;
            in_data  = dv;
            in_dir   = 1'(k % 2);
            @(negedge clk);
            if (u_in_ready) acc++;
            else begin
                stl++;
                if (stl == 1) frz = u_out_data;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stall_accepts", 64'(acc), 64'(LAT));
        chk("stall_frozen", 64'(u_out_data), 64'(frz));
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            if (u_out_valid && seen == k) seen++;
            @(posedge clk); #1;
        end
        chk("drain_burst", 64'(seen), 64'(LAT));

        // Three back-to-back vectors killed by a flush that also offers a fourth.
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < N; i++) dv[i*W +: W] = W'($urandom_range(0, 255));
            in_valid = 1'b1;
            in_data  = dv;
            @(posedge clk); #1;
        end
        flush   = 1'b1;
        in_data = ~dv;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        count_valid(LAT + 3, seen);
        chk("flush_no_out", 64'(seen), 64'd0);
        chk("flush_model_empty", 64'(q_u.size()), 64'd0);
        a = '{3, 3, 1, 1, 2, 2, 0, 0};
        send_vec(pk(a), 1'b0, 1'b0, t0);
        wait_out(t1);
        chk("flush_lat", 64'(t1 - t0), 64'(LAT));
        a = '{6, 7, 2, 3, 4, 5, 0, 1};  chk("flush_next_idx", 64'(cap_iu), 64'(pkx(a)));

        // Reset while vectors are in flight.
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < N; i++) dv[i*W +: W] = W'($urandom_range(0, 255));
            in_valid = 1'b1;
            in_data  = dv;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_valid(LAT + 2, seen);
        chk("rst_no_out", 64'(seen), 64'd0);
        a = '{1, 0, 1, 0, 1, 0, 1, 0};
        send_vec(pk(a), 1'b1, 1'b0, t0);
        wait_out(t1);
        chk("rst_lat", 64'(t1 - t0), 64'(LAT));
        a = '{0, 2, 4, 6, 1, 3, 5, 7};  chk("rst_next_idx", 64'(cap_iu), 64'(pkx(a)));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
